wb_burst_reader: RTL and testbench
==================================

WB_BURST_READER -- requirements
Module: wb_burst_reader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the output FIFO depth in 32-bit words (power of 2, at least 2).
REQ-002 The block SHALL have parameter BURST, default 8, meaning the maximum beats per Wishbone burst (1 to DEPTH).
REQ-003 Port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port start, input, 1 bit: one-cycle job request, honoured only in IDLE.
REQ-006 Port base_adr, input, 32 bits: byte address of the first word; bits [1:0] are ignored and treated as 0.
REQ-007 Port nwords, input, 16 bits: number of words to fetch; 0 means an empty job.
REQ-008 Port busy, output, 1 bit: job in progress.
REQ-009 Port done, output, 1 bit: one-cycle pulse at job end.
REQ-010 Port error, output, 1 bit: sticky flag, set on err or rty, cleared by the next accepted start.
REQ-011 Ports wb_adr_o (output, 32), wb_dat_i (input, 32), wb_dat_o (output, 32), wb_we_o (output, 1), wb_sel_o (output, 4), wb_stb_o (output, 1), wb_cyc_o (output, 1), wb_cti_o (output, 3), wb_bte_o (output, 2), wb_ack_i (input, 1), wb_err_i (input, 1), wb_rty_i (input, 1): the Wishbone B4 registered-feedback master port.
REQ-012 Ports out_data (output, 32), out_valid (output, 1), out_ready (input, 1): the output stream; a word transfers on a cycle where out_valid and out_ready are both 1.

Function
REQ-013 Constant outputs SHALL be wb_we_o=0, wb_dat_o=0, wb_sel_o=4'hF and wb_bte_o=2'b00 (linear).
REQ-014 The FSM SHALL have states IDLE, WAIT_SPACE, BURST and FINISH.
REQ-015 IDLE with start=1 SHALL latch the word-aligned address and nwords into a remaining counter, clear error and go to WAIT_SPACE; if nwords=0 it SHALL go to FINISH instead.
REQ-016 WAIT_SPACE SHALL compute len = min(BURST, remaining) and go to BURST on the first cycle where free FIFO slots >= len, counting words already committed by the running burst.
REQ-017 In BURST, wb_cyc_o and wb_stb_o SHALL be 1 and held until the last acknowledged beat.
REQ-018 In BURST, wb_cti_o SHALL be 3'b010 on every beat except the last beat of the burst, which SHALL be 3'b111; a burst with len=1 SHALL use 3'b111 only.
REQ-019 On each wb_ack_i=1, the block SHALL write wb_dat_i into the FIFO, add 4 to wb_adr_o and decrement remaining and the beat counter, all in the same cycle.
REQ-020 After the last ack of a burst, the block SHALL deassert cyc and stb in the next cycle, for at least 1 idle cycle, then go to WAIT_SPACE if remaining > 0, else FINISH.
REQ-021 wb_err_i=1 or wb_rty_i=1 SHALL set error, drop cyc and stb next cycle, discard that beat and go to FINISH.
REQ-022 FINISH SHALL wait until the FIFO is empty, then pulse done for 1 cycle and return to IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 The FIFO SHALL be synchronous first-word-fall-through: out_valid=1 whenever it is non-empty, and out_data is the head word.
REQ-025 A simultaneous FIFO push and pop SHALL leave the level unchanged.
REQ-026 The FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-027 Overflow SHALL be impossible by construction of REQ-016; an assertion SHALL check that no push occurs when the FIFO is full.
REQ-028 The address SHALL wrap modulo 2^32 without error.
REQ-029 A start received outside IDLE SHALL be ignored.

Reset
REQ-030 While rst_n=0, the block SHALL asynchronously force the IDLE state, FIFO empty, busy=0, done=0, error=0, wb_cyc_o=0, wb_stb_o=0, wb_cti_o=3'b000, wb_adr_o=0 and out_valid=0.
REQ-031 Reset in the middle of a burst SHALL drop cyc immediately and discard all FIFO contents; the block SHALL drive no further Wishbone activity until a new start.

Verification
REQ-032 Scenario: base_adr=0x100, nwords=20, slave acks every cycle, out_ready=1 -> bursts of 8, 8 and 4 beats with cti 010...111; the stream delivers 20 words from addresses 0x100 to 0x14C in order; done pulses once.
REQ-033 Scenario: nwords=40, out_ready=0 for 100 cycles -> exactly 2 bursts (16 words), then the FIFO is full with cyc=0; releasing out_ready resumes fetching until all 40 words are delivered.
REQ-034 Scenario: nwords=3 -> a single burst of len=3 whose beat 3 has cti=111.
REQ-035 Scenario: nwords=0 -> no cyc assertion; done pulses 1 cycle after start (via FINISH).
REQ-036 Scenario: wb_err_i on beat 5 of the first burst -> error=1, cyc low next cycle, 4 words delivered, then done; a new start clears error.
REQ-037 Scenario: rst_n low in mid-burst with 6 words in the FIFO -> outputs at reset values within the same cycle; out_valid=0 after release.

Source files
------------

// File: rtl/wb_burst_reader.sv
// Wishbone B4 burst read master that fetches a block of 32-bit words into a
// first-word-fall-through FIFO and presents them as a valid/ready stream.
module wb_burst_reader #(
   parameter int DEPTH = 16,
   parameter int BURST = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] base_adr,
   input  logic [15:0] nwords,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [31:0] wb_adr_o,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_we_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_stb_o,
   output logic        wb_cyc_o,
   output logic [2:0]  wb_cti_o,
   output logic [1:0]  wb_bte_o,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,
   input  logic        wb_rty_i,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:0]  dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [2:0] CTI_INCR = 3'b010;
   localparam logic [2:0] CTI_EOB  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_SPACE = 2'd1,
      ST_BURST      = 2'd2,
      ST_FINISH     = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [31:0]     adr_q, adr_d;
   logic [15:0]     rem_q, rem_d;
   logic [15:0]     beat_q, beat_d;
   logic            cyc_q, cyc_d;
   logic [2:0]      cti_q, cti_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            error_q, error_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [31:0]     mem_q [DEPTH];

   logic            push;
   logic            pop;
   logic [15:0]     len;
   logic [15:0]     free;

   always_comb begin
      state_d  = state_q;
      adr_d    = adr_q;
      rem_d    = rem_q;
      beat_d   = beat_q;
      cyc_d    = cyc_q;
      cti_d    = cti_q;
      done_d   = 1'b0;
      error_d  = error_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      push     = 1'b0;
      pop      = (count_q != '0) && out_ready;
      len      = (rem_q < 16'(BURST)) ? rem_q : 16'(BURST);
      // No burst is in flight while waiting, so every free slot is uncommitted.
      free     = 16'(DEPTH) - 16'(count_q);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               adr_d   = base_adr & 32'hFFFF_FFFC;
               rem_d   = nwords;
               error_d = 1'b0;
               state_d = (nwords == 16'd0) ? ST_FINISH : ST_WAIT_SPACE;
            end
         end
         ST_WAIT_SPACE: begin
            if (free >= len) begin
               cyc_d   = 1'b1;
               beat_d  = len;
               cti_d   = (len == 16'd1) ? CTI_EOB : CTI_INCR;
               state_d = ST_BURST;
            end
         end
         ST_BURST: begin
            if (wb_err_i || wb_rty_i) begin
               error_d = 1'b1;
               cyc_d   = 1'b0;
               cti_d   = 3'b000;
               state_d = ST_FINISH;
            end else if (wb_ack_i) begin
               push   = 1'b1;
               adr_d  = adr_q + 32'd4;
               rem_d  = rem_q - 16'd1;
               beat_d = beat_q - 16'd1;
               if (beat_q == 16'd1) begin
                  // Dropping cyc here yields the mandatory idle cycle in WAIT_SPACE.
                  cyc_d   = 1'b0;
                  cti_d   = 3'b000;
                  state_d = (rem_q != 16'd1) ? ST_WAIT_SPACE : ST_FINISH;
               end else begin
                  cti_d = (beat_q == 16'd2) ? CTI_EOB : CTI_INCR;
               end
            end
         end
         ST_FINISH: begin
            if (count_q == '0) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         adr_q    <= 32'd0;
         rem_q    <= 16'd0;
         beat_q   <= 16'd0;
         cyc_q    <= 1'b0;
         cti_q    <= 3'b000;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         adr_q    <= adr_d;
         rem_q    <= rem_d;
         beat_q   <= beat_d;
         cyc_q    <= cyc_d;
         cti_q    <= cti_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         error_q  <= error_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wb_dat_i;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && (count_q == CW'(DEPTH))));

   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign wb_adr_o  = adr_q;
   assign wb_cyc_o  = cyc_q;
   assign wb_stb_o  = cyc_q;
   assign wb_cti_o  = cti_q;
   assign wb_dat_o  = 32'd0;
   assign wb_we_o   = 1'b0;
   assign wb_sel_o  = 4'hF;
   assign wb_bte_o  = 2'b00;
   assign out_valid = (count_q != '0);
   assign out_data  = mem_q[rd_ptr_q];
   assign dbg_state = state_q;

endmodule

// File: tb/tb_wb_burst_reader.sv
// Directed bench for wb_burst_reader: zero-wait Wishbone slave model with
// error injection, stream scoreboard and burst/cti monitor.
module tb_wb_burst_reader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] base_adr;
   logic [15:0] nwords;
   logic        busy, done, error;
   logic [31:0] wb_adr_o, wb_dat_i, wb_dat_o;
   logic        wb_we_o, wb_stb_o, wb_cyc_o;
   logic [3:0]  wb_sel_o;
   logic [2:0]  wb_cti_o;
   logic [1:0]  wb_bte_o;
   logic        wb_ack_i, wb_err_i, wb_rty_i;
   logic [31:0] out_data;
   logic        out_valid, out_ready;
   logic [1:0]  dbg_state;

   wb_burst_reader #(.DEPTH(16), .BURST(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_adr(base_adr), .nwords(nwords),
      .busy(busy), .done(done), .error(error),
      .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
      .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_cti_o(wb_cti_o),
      .wb_bte_o(wb_bte_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .dbg_state(dbg_state)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave model: data word is a fixed scramble of its byte address
   function automatic logic [31:0] wdat(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   logic err_en;
   int   err_beat;
   int   beat_cnt;
   int   total_acks;

   assign wb_dat_i = wdat(wb_adr_o);
   assign wb_err_i = wb_cyc_o & wb_stb_o & err_en & (beat_cnt == err_beat - 1);
   assign wb_ack_i = wb_cyc_o & wb_stb_o & ~wb_err_i;
   assign wb_rty_i = 1'b0;

   initial begin
      beat_cnt   = 0;
      total_acks = 0;
   end

   always @(posedge clk) begin
      if (!wb_cyc_o) beat_cnt <= 0;
      else if (wb_ack_i) beat_cnt <= beat_cnt + 1;
      if (wb_ack_i) total_acks <= total_acks + 1;
   end

   // Monitor: stream words, done pulses, burst lengths and cti pattern
   logic [31:0] got_q[$];
   int          len_q[$];
   int          bursts, done_cnt, cti_bad, cur_len;
   logic        cyc_prev, saw_err;
   logic [2:0]  last_cti;

   initial begin
      bursts = 0; done_cnt = 0; cti_bad = 0; cur_len = 0;
      cyc_prev = 1'b0; saw_err = 1'b0; last_cti = 3'b000;
   end

   always @(negedge clk) begin
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (done) done_cnt++;
      if (wb_cyc_o && !cyc_prev) bursts++;
      if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
         if (cur_len > 0 && last_cti != 3'b010) cti_bad++;
         last_cti = wb_cti_o;
         cur_len++;
      end
      if (wb_cyc_o && wb_stb_o && (wb_err_i || wb_rty_i)) saw_err = 1'b1;
      if (!wb_cyc_o && cyc_prev) begin
         len_q.push_back(cur_len);
         if (!saw_err && last_cti != 3'b111) cti_bad++;
         cur_len = 0;
         saw_err = 1'b0;
      end
      cyc_prev = wb_cyc_o;
   end

   // Scoreboard
   logic [31:0] exp_q[$];
   int tests, fails;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic expect_words(input logic [31:0] a0, input int n);
      logic [31:0] a;
      exp_q.delete();
      a = a0;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(wdat(a));
         a = a + 32'd4;
      end
   endtask

   task automatic check_stream(input string tag, input int g0);
      check({tag, "_count"}, 32'(got_q.size() - g0), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (g0 + i < got_q.size()) check($sformatf("%s_w%0d", tag, i), got_q[g0 + i], exp_q[i]);
      end
   endtask

   task automatic check_len(input string tag, input int idx, input int exp);
      if (idx < len_q.size()) check(tag, 32'(len_q[idx]), 32'(exp));
      else check(tag, 32'hFFFF_FFFF, 32'(exp));
   endtask

   // Drivers
   task automatic start_job(input logic [31:0] adr, input logic [15:0] n);
      @(posedge clk); #1;
      start = 1'b1; base_adr = adr; nwords = n;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check(tag, {31'd0, seen}, 32'd1);
      repeat (2) @(negedge clk);
   endtask

   int g0, b0, d0, l0, a0;
   logic hit;

   initial begin
      tests = 0; fails = 0;
      rst_n = 1'b0; start = 1'b0; base_adr = 32'd0; nwords = 16'd0;
      out_ready = 1'b0; err_en = 1'b0; err_beat = 0;

      // Reset values and constant outputs
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
      check("rst_cti", {29'd0, wb_cti_o}, 32'd0);
      check("rst_adr", wb_adr_o, 32'd0);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("const_outs", {wb_dat_o[15:0], 9'd0, wb_we_o, wb_sel_o, wb_bte_o}, {16'd0, 9'd0, 1'b0, 4'hF, 2'b00});
      @(posedge clk); #1 rst_n = 1'b1;

      // 20 words at 0x100: bursts 8, 8, 4
      out_ready = 1'b1;
      expect_words(32'h100, 20);
      g0 = got_q.size(); b0 = bursts; d0 = done_cnt; l0 = len_q.size();
      start_job(32'h100, 16'd20);
      wait_done("s1_done", 500);
      check_stream("s1", g0);
      check("s1_bursts", 32'(bursts - b0), 32'd3);
      check_len("s1_len0", l0, 8);
      check_len("s1_len1", l0 + 1, 8);
      check_len("s1_len2", l0 + 2, 4);
      check("s1_done_cnt", 32'(done_cnt - d0), 32'd1);
      check("s1_cti", 32'(cti_bad), 32'd0);
      check("s1_busy_idle", {31'd0, busy}, 32'd0);

      // 40 words with consumer stalled: FIFO fills after two bursts
      out_ready = 1'b0;
      expect_words(32'h2000_0000, 40);
      g0 = got_q.size(); b0 = bursts; d0 = done_cnt; l0 = len_q.size();
      start_job(32'h2000_0003, 16'd40);
      repeat (100) @(negedge clk);
      check("s2_stall_bursts", 32'(bursts - b0), 32'd2);
      check("s2_stall_cyc", {31'd0, wb_cyc_o}, 32'd0);
      check("s2_stall_valid", {31'd0, out_valid}, 32'd1);
      check("s2_stall_busy", {31'd0, busy}, 32'd1);
      check("s2_stall_out", 32'(got_q.size() - g0), 32'd0);
      @(posedge clk); #1 out_ready = 1'b1;
      wait_done("s2_done", 1000);
      check_stream("s2", g0);
      check("s2_bursts", 32'(bursts - b0), 32'd5);
      for (int i = 0; i < 5; i++) check_len($sformatf("s2_len%0d", i), l0 + i, 8);
      check("s2_done_cnt", 32'(done_cnt - d0), 32'd1);
      check("s2_cti", 32'(cti_bad), 32'd0);

      // 3 words crossing the top of the address space: single burst of 3
      expect_words(32'hFFFF_FFF8, 3);
      g0 = got_q.size(); b0 = bursts; l0 = len_q.size();
      start_job(32'hFFFF_FFF8, 16'd3);
      wait_done("s3_done", 200);
      check_stream("s3", g0);
      check("s3_bursts", 32'(bursts - b0), 32'd1);
      check_len("s3_len", l0, 3);
      check("s3_cti", 32'(cti_bad), 32'd0);
      check("s3_error", {31'd0, error}, 32'd0);

      // Empty job goes straight through FINISH
      b0 = bursts;
      start_job(32'h800, 16'd0);
      @(negedge clk);
      check("s4_busy", {31'd0, busy}, 32'd1);
      check("s4_done_early", {31'd0, done}, 32'd0);
      @(negedge clk);
      check("s4_done", {31'd0, done}, 32'd1);
      check("s4_busy_after", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("s4_done_pulse", {31'd0, done}, 32'd0);
      check("s4_no_cyc", 32'(bursts - b0), 32'd0);

      // Bus error on beat 5 of the first burst
      err_en = 1'b1; err_beat = 5;
      expect_words(32'h300, 4);
      g0 = got_q.size(); d0 = done_cnt; l0 = len_q.size();
      start_job(32'h300, 16'd16);
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (wb_err_i) begin
            hit = 1'b1;
            break;
         end
      end
      check("s5_err_seen", {31'd0, hit}, 32'd1);
      @(negedge clk);
      check("s5_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
      check("s5_error", {31'd0, error}, 32'd1);
      err_en = 1'b0;
      wait_done("s5_done", 200);
      check_stream("s5", g0);
      check_len("s5_len", l0, 4);
      check("s5_done_cnt", 32'(done_cnt - d0), 32'd1);
      check("s5_error_sticky", {31'd0, error}, 32'd1);
      expect_words(32'h400, 1);
      g0 = got_q.size();
      start_job(32'h400, 16'd1);
      @(negedge clk);
      check("s5_error_clear", {31'd0, error}, 32'd0);
      wait_done("s5b_done", 200);
      check_stream("s5b", g0);

      // Asynchronous reset mid-burst with 6 words buffered
      out_ready = 1'b0;
      a0 = total_acks;
      start_job(32'h500, 16'd16);
      hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (total_acks - a0 == 6) begin
            hit = 1'b1;
            break;
         end
      end
      check("s6_six_acks", {31'd0, hit}, 32'd1);
      check("s6_cyc_mid", {31'd0, wb_cyc_o}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("s6_rst_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
      check("s6_rst_valid", {31'd0, out_valid}, 32'd0);
      check("s6_rst_busy", {31'd0, busy}, 32'd0);
      check("s6_rst_adr_cti", {wb_adr_o[28:0], wb_cti_o}, 32'd0);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1; out_ready = 1'b1;
      b0 = bursts;
      repeat (10) @(negedge clk);
      check("s6_post_valid", {31'd0, out_valid}, 32'd0);
      check("s6_post_cyc", {31'd0, wb_cyc_o}, 32'd0);
      check("s6_post_bursts", 32'(bursts - b0), 32'd0);
      check("s6_post_busy", {31'd0, busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
